// File: rtl/ann_pkg.sv
// ann_pkg: shared widths, sample type and feeder state encoding for the ANN front end
package ann_pkg;
  localparam int DW = 10;
  localparam int N_IN = 30;
  localparam int N_OUT = 3;
  typedef logic [DW-1:0] sample_t;
  typedef enum logic [1:0] {FILL, RUN, RESULT, SHIFT} feed_state_t;
endpackage

// File: rtl/ann_window_buf.sv
// ann_window_buf: N_IN-entry sample window with indexed write and slide-by-STRIDE
module ann_window_buf
  import ann_pkg::*;
#(
  parameter int DW = ann_pkg::DW,
  parameter int N_IN = ann_pkg::N_IN,
  parameter int STRIDE = 10,
  localparam int IW = $clog2(N_IN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_idx,
  input  logic [DW-1:0]    wr_data,
  input  logic             shift,
  output logic [N_IN*DW-1:0] window
);
  logic [DW-1:0] win [N_IN];
  logic [DW-1:0] shifted [N_IN];
  for (genvar i = 0; i < N_IN; i++) begin : g_win
    if (i < N_IN - STRIDE) begin : g_keep
      assign shifted[i] = win[i+STRIDE];
    end else begin : g_clear
      assign shifted[i] = '0;
    end
    assign window[i*DW +: DW] = win[i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      win <= '{default: '0};
    end else if (shift) begin
      win <= shifted;
    end else begin
      for (int k = 0; k < N_IN; k++)
        if (wr_en && wr_idx == IW'(k)) win[k] <= wr_data;
    end
  end
endmodule

// File: rtl/ann_frame_feeder.sv
// ann_frame_feeder: sliding-window sample collector, ANN launch/timeout control and result handshake
module ann_frame_feeder
  import ann_pkg::*;
#(
  parameter int DW = ann_pkg::DW,
  parameter int N_IN = ann_pkg::N_IN,
  parameter int N_OUT = ann_pkg::N_OUT,
  parameter int STRIDE = 10,
  parameter int TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  input  logic [DW-1:0]       s_data,
  output logic                s_ready,
  input  logic                train_mode,
  input  logic [N_OUT*DW-1:0] target_in,
  output logic [N_IN*DW-1:0]  ann_in,
  output logic                ann_start,
  output logic                ann_training,
  output logic [N_OUT*DW-1:0] ann_target,
  input  logic                ann_done,
  input  logic [N_OUT*DW-1:0] ann_out,
  output logic                res_valid,
  output logic [N_OUT*DW-1:0] res_data,
  input  logic                res_ready,
  output logic                timeout_err
);
  localparam int IW = $clog2(N_IN + 1);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  feed_state_t state, next;
  logic [IW-1:0] wr_idx;
  logic [TW-1:0] timer;
  logic accept, launch, expired;
  assign s_ready = state == FILL;
  assign ann_start = state == RUN;
  assign res_valid = state == RESULT;
  assign accept = s_ready && s_valid;
  assign launch = accept && wr_idx == IW'(N_IN - 1);
  assign expired = timer == TW'(TIMEOUT - 1);
  assign timeout_err = ann_start && expired && !ann_done;
  always_comb begin
    next = state;
    case (state)
      FILL:    next = launch ? RUN : FILL;
      RUN:     next = ann_done ? RESULT : expired ? SHIFT : RUN;
      RESULT:  next = res_ready ? SHIFT : RESULT;
      default: next = FILL;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      wr_idx <= '0;
      timer <= '0;
      ann_training <= 1'b0;
      ann_target <= '0;
      res_data <= '0;
    end else begin
      state <= next;
      wr_idx <= state == SHIFT ? IW'(N_IN - STRIDE) : accept ? wr_idx + 1'b1 : wr_idx;
      timer <= (state == RUN && next == RUN) ? timer + 1'b1 : '0;
      if (launch) begin
        ann_training <= train_mode;
        ann_target <= target_in;
      end
      if (ann_start && ann_done) res_data <= ann_out;
    end
  end
  ann_window_buf #(.DW(DW), .N_IN(N_IN), .STRIDE(STRIDE)) u_buf (
    .clk(clk),
    .rst(rst),
    .wr_en(accept),
    .wr_idx(wr_idx),
    .wr_data(s_data),
    .shift(state == SHIFT),
    .window(ann_in)
  );
endmodule

// File: tb/tb_ann_frame_feeder.sv
// tb_ann_frame_feeder: directed checks of fill, launch, capture, slide, timeout, latch and reset
module tb_ann_frame_feeder;
  logic clk = 0, rst = 1;
  logic s_valid = 0, s_ready, train_mode = 0;
  logic [9:0] s_data = '0;
  logic [29:0] target_in = '0, ann_target, ann_out = '0, res_data;
  logic [299:0] ann_in;
  logic ann_start, ann_training, ann_done = 0, res_valid, res_ready = 0, timeout_err;
  int n_chk = 0, n_pass = 0;
  logic [29:0] held;
  ann_frame_feeder #(.STRIDE(10), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .train_mode(train_mode), .target_in(target_in), .ann_in(ann_in), .ann_start(ann_start),
    .ann_training(ann_training), .ann_target(ann_target), .ann_done(ann_done), .ann_out(ann_out),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [9:0] el(input int i);
    return ann_in[i*10 +: 10];
  endfunction
  task automatic feed(input int n, input int base, input bit pat12);
    for (int k = 0; k < n; k++) begin
      s_valid = 1;
      s_data = 10'(pat12 ? base + k % 12 : base + k);
      if (k == n - 1) check("pre_launch_idle", ann_start, 0);
      tick();
    end
    s_valid = 0;
  endtask
  initial begin
    tick(2);
    rst = 0;
    check("rst_s_ready", s_ready, 1);
    check("rst_start", ann_start, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_ann_in", ann_in == '0, 1);
    feed(30, 284, 1);
    check("fill_s_ready_low", s_ready, 0);
    check("fill_start", ann_start, 1);
    check("fill_in0", el(0), 284);
    check("fill_in29", el(29), 289);
    check("fill_training", ann_training, 0);
    tick(3);
    ann_done = 1;
    ann_out = {10'd2, 10'd2, 10'd2};
    tick();
    ann_done = 0;
    ann_out = {10'd9, 10'd9, 10'd9};
    check("done_res_valid", res_valid, 1);
    check("done_res_data", res_data, {10'd2, 10'd2, 10'd2});
    check("done_start_low", ann_start, 0);
    check("done_s_ready", s_ready, 0);
    for (int k = 0; k < 5; k++) begin
      ann_done = k == 2;
      tick();
      check("hold_res_data", res_data, {10'd2, 10'd2, 10'd2});
      check("hold_res_valid", res_valid, 1);
    end
    ann_done = 0;
    res_ready = 1;
    tick();
    res_ready = 0;
    check("shift_res_valid", res_valid, 0);
    check("shift_s_ready", s_ready, 0);
    tick();
    check("slide_s_ready", s_ready, 1);
    check("slide_in0", el(0), 294);
    check("slide_in19", el(19), 289);
    check("slide_in20", el(20), 0);
    train_mode = 1;
    target_in = {10'd2, 10'd2, 10'd2};
    feed(10, 500, 0);
    check("refill_start", ann_start, 1);
    check("refill_in0", el(0), 294);
    check("refill_in20", el(20), 500);
    check("refill_in29", el(29), 509);
    check("latch_training", ann_training, 1);
    check("latch_target", ann_target, {10'd2, 10'd2, 10'd2});
    train_mode = 0;
    target_in = {10'd7, 10'd7, 10'd7};
    tick();
    check("latch_training_hold", ann_training, 1);
    check("latch_target_hold", ann_target, {10'd2, 10'd2, 10'd2});
    tick(13);
    check("to_not_yet", timeout_err, 0);
    check("to_start_still", ann_start, 1);
    tick();
    check("to_pulse", timeout_err, 1);
    tick();
    check("to_pulse_end", timeout_err, 0);
    check("to_no_result", res_valid, 0);
    check("to_start_low", ann_start, 0);
    tick();
    check("to_s_ready", s_ready, 1);
    check("to_slide_in0", el(0), 292);
    check("to_slide_in10", el(10), 500);
    check("to_slide_in19", el(19), 509);
    check("to_slide_in20", el(20), 0);
    feed(10, 600, 0);
    check("run3_start", ann_start, 1);
    check("run3_training", ann_training, 0);
    check("run3_target", ann_target, {10'd7, 10'd7, 10'd7});
    rst = 1;
    tick();
    rst = 0;
    check("rstrun_start", ann_start, 0);
    check("rstrun_ann_in", ann_in == '0, 1);
    check("rstrun_target", ann_target, 0);
    check("rstrun_training", ann_training, 0);
    check("rstrun_s_ready", s_ready, 1);
    feed(30, 100, 0);
    check("fresh_start", ann_start, 1);
    check("fresh_in0", el(0), 100);
    ann_done = 1;
    ann_out = {10'd5, 10'd4, 10'd3};
    tick();
    ann_done = 0;
    check("fresh_res", res_data, {10'd5, 10'd4, 10'd3});
    rst = 1;
    tick();
    rst = 0;
    check("rstres_valid", res_valid, 0);
    check("rstres_data", res_data, 0);
    check("rstres_s_ready", s_ready, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
